// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and small bit-vector helpers.
package irq_ctrl_pkg;

    // IRQ register window, placed clear of the timer registers
    localparam logic [15:0] ADDR_IRQ_MASK = 16'hFF20;
    localparam logic [15:0] ADDR_IRQ_PEND = 16'hFF21;
    localparam logic [15:0] ADDR_IRQ_VEC  = 16'hFF22;
    localparam logic [15:0] ADDR_IRQ_EOI  = 16'hFF23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    // Bits that correspond to implemented request lines
    function automatic logic [7:0] src_valid_mask(input int n);
        return 8'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the eight active request bits.
module irq_prio_enc (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) idx_o = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected pending latch, CPU mask, and a single
// outstanding request held through ack until the CPU writes end-of-interrupt.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        addr,
    input  logic               we,
    input  logic [7:0]         di,
    // 'do' is a reserved word, so the read-data port carries a suffix
    output logic [7:0]         do_o,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq,
    output logic [2:0]         irq_vec,
    input  logic               irq_ack
);

    localparam logic [7:0] SRC_MASK = src_valid_mask(NUM_SRC);

    irq_state_e state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] vec_q, vec_d;

    logic [7:0] src8, rise, active, w1c_clr, ack_clr;
    logic       wr_mask, wr_pend, wr_eoi, in_service;
    logic [2:0] enc_idx;
    logic       enc_vld;

    always_comb begin
        src8                = '0;
        src8[NUM_SRC-1:0]   = src;
    end

    assign wr_mask = we && (addr == ADDR_IRQ_MASK);
    assign wr_pend = we && (addr == ADDR_IRQ_PEND);
    assign wr_eoi  = we && (addr == ADDR_IRQ_EOI);

    assign rise    = src8 & ~src_q;
    assign active  = pend_q & mask_q;
    assign w1c_clr = wr_pend ? di : 8'h00;

    irq_prio_enc u_prio (
        .req_i (active),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    state_d = ST_REQ;
                    vec_d   = enc_idx;
                end
            end
            ST_REQ: begin
                // Ack wins if the request is withdrawn in the same cycle
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                    ack_clr = onehot8(vec_q);
                end else if (!active[vec_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // New edges override any clear landing in the same cycle
    always_comb begin
        src_d  = src8;
        pend_d = ((pend_q & ~(w1c_clr | ack_clr)) | rise) & SRC_MASK;
        mask_d = wr_mask ? (di & SRC_MASK) : mask_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
        end
    end

    assign in_service = (state_q == ST_SERVICE);
    assign irq        = (state_q == ST_REQ);
    assign irq_vec    = vec_q;

    always_comb begin
        do_o = 8'h00;
        case (addr)
            ADDR_IRQ_MASK: do_o = mask_q;
            ADDR_IRQ_PEND: do_o = pend_q;
            ADDR_IRQ_VEC:  do_o = {in_service, 4'b0000, vec_q};
            default:       do_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations are queued as stimulus is driven
// and popped against DUT observations sampled on the falling clock edge.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  di;
    logic [7:0]  do_o;
    logic [7:0]  src;
    logic        irq;
    logic [2:0]  irq_vec;
    logic        irq_ack;

    irq_ctrl #(.NUM_SRC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .we      (we),
        .di      (di),
        .do_o    (do_o),
        .src     (src),
        .irq     (irq),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic exp_v(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic observe(input logic [7:0] obs);
        exp_t e;
        n_tot++;
        if (sbq.size() == 0) begin
            $error("FAIL sb_empty: observed %h with no queued expectation", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; we = 1'b1; di = d;
        step();
        we = 1'b0; addr = '0; di = '0;
    endtask

    task automatic rd_obs(input logic [15:0] a);
        logic [7:0] v;
        addr = a;
        #1;
        v = do_o;
        addr = '0;
        observe(v);
    endtask

    task automatic obs_irq();
        observe({7'b0, irq});
    endtask

    task automatic obs_vec();
        observe({5'b0, irq_vec});
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr = '0; we = 1'b0; di = '0; src = '0; irq_ack = 1'b0;
        repeat (3) step();
        exp_v("irq_in_reset", 8'h00); obs_irq();
        rst = 1'b1;
        step();

        // Reset state
        exp_v("rst_irq", 8'h00);       obs_irq();
        exp_v("rst_mask", 8'h00);      rd_obs(ADDR_IRQ_MASK);
        exp_v("rst_pend", 8'h00);      rd_obs(ADDR_IRQ_PEND);
        exp_v("rst_vec", 8'h00);       rd_obs(ADDR_IRQ_VEC);
        exp_v("unmapped_rd", 8'h00);   rd_obs(16'h1234);

        // Single source 0 through ack and EOI
        bus_wr(ADDR_IRQ_MASK, 8'h01);
        exp_v("mask_rb", 8'h01);       rd_obs(ADDR_IRQ_MASK);
        src = 8'h01;
        exp_v("s0_pend_k", 8'h01);
        exp_v("s0_irq_k", 8'h00);
        exp_v("s0_irq_k1", 8'h01);
        exp_v("s0_vec_k1", 8'h00);
        exp_v("s0_vecreg_req", 8'h00);
        step();
        src = 8'h00;
        rd_obs(ADDR_IRQ_PEND);
        obs_irq();
        step();
        obs_irq();
        obs_vec();
        rd_obs(ADDR_IRQ_VEC);
        exp_v("s0_irq_ack", 8'h00);
        exp_v("s0_pend_ack", 8'h00);
        exp_v("s0_vecreg_svc", 8'h80);
        ack();
        obs_irq();
        rd_obs(ADDR_IRQ_PEND);
        rd_obs(ADDR_IRQ_VEC);
        exp_v("s0_vecreg_eoi", 8'h00);
        bus_wr(ADDR_IRQ_EOI, 8'h5A);
        rd_obs(ADDR_IRQ_VEC);

        // Simultaneous sources 5 and 2, then a higher-priority arrival in REQ
        bus_wr(ADDR_IRQ_MASK, 8'hFF);
        src = 8'h24;
        exp_v("dual_pend", 8'h24);
        exp_v("dual_irq", 8'h01);
        exp_v("dual_vec", 8'h02);
        step();
        rd_obs(ADDR_IRQ_PEND);
        step();
        obs_irq();
        obs_vec();
        src = 8'h25;
        exp_v("hp_pend", 8'h25);
        exp_v("hp_vec_held", 8'h02);
        exp_v("eoi_in_req_irq", 8'h01);
        step();
        rd_obs(ADDR_IRQ_PEND);
        obs_vec();
        bus_wr(ADDR_IRQ_EOI, 8'h00);
        obs_irq();
        exp_v("dual_ack_pend", 8'h21);
        exp_v("dual_ack_vecreg", 8'h82);
        exp_v("eoi_e_irq", 8'h00);
        exp_v("rereq_irq", 8'h01);
        exp_v("rereq_vec", 8'h00);
        ack();
        rd_obs(ADDR_IRQ_PEND);
        rd_obs(ADDR_IRQ_VEC);
        bus_wr(ADDR_IRQ_EOI, 8'h00);
        obs_irq();
        step();
        obs_irq();
        obs_vec();
        exp_v("s0b_ack_pend", 8'h20);
        exp_v("s5_irq", 8'h01);
        exp_v("s5_vec", 8'h05);
        exp_v("s5_ack_pend", 8'h00);
        ack();
        rd_obs(ADDR_IRQ_PEND);
        bus_wr(ADDR_IRQ_EOI, 8'h00);
        step();
        obs_irq();
        obs_vec();
        ack();
        rd_obs(ADDR_IRQ_PEND);
        bus_wr(ADDR_IRQ_EOI, 8'h00);
        src = 8'h00;
        step();

        // Withdrawal by W1C while requesting
        src = 8'h04;
        step();
        src = 8'h00;
        exp_v("wd_irq", 8'h01);
        exp_v("wd_vec", 8'h02);
        exp_v("wd_pend", 8'h00);
        exp_v("wd_irq_w", 8'h01);
        exp_v("wd_irq_drop", 8'h00);
        exp_v("wd_vecreg", 8'h02);
        exp_v("wd_idle", 8'h00);
        step();
        obs_irq();
        obs_vec();
        bus_wr(ADDR_IRQ_PEND, 8'h04);
        rd_obs(ADDR_IRQ_PEND);
        obs_irq();
        step();
        obs_irq();
        rd_obs(ADDR_IRQ_VEC);
        step();
        obs_irq();

        // W1C colliding with a fresh edge, then a held level
        bus_wr(ADDR_IRQ_MASK, 8'h00);
        src = 8'h08;
        exp_v("set_wins", 8'h08);
        exp_v("level_clr", 8'h00);
        exp_v("level_no_edge", 8'h00);
        bus_wr(ADDR_IRQ_PEND, 8'h08);
        rd_obs(ADDR_IRQ_PEND);
        bus_wr(ADDR_IRQ_PEND, 8'h08);
        rd_obs(ADDR_IRQ_PEND);
        step();
        rd_obs(ADDR_IRQ_PEND);

        // Reset while in SERVICE, src[3] still high across release
        bus_wr(ADDR_IRQ_MASK, 8'h02);
        src = 8'h0A;
        step();
        src = 8'h08;
        exp_v("s1_irq", 8'h01);
        exp_v("s1_vec", 8'h01);
        exp_v("s1_vecreg_svc", 8'h81);
        step();
        obs_irq();
        obs_vec();
        ack();
        rd_obs(ADDR_IRQ_VEC);
        rst = 1'b0;
        #1;
        exp_v("mid_rst_irq", 8'h00);
        exp_v("mid_rst_mask", 8'h00);
        exp_v("mid_rst_vecreg", 8'h00);
        exp_v("mid_rst_pend", 8'h00);
        exp_v("mid_rst_vec", 8'h00);
        obs_irq();
        rd_obs(ADDR_IRQ_MASK);
        rd_obs(ADDR_IRQ_VEC);
        rd_obs(ADDR_IRQ_PEND);
        obs_vec();
        step();
        rst = 1'b1;
        exp_v("rel_pend", 8'h08);
        exp_v("rel_irq", 8'h00);
        step();
        rd_obs(ADDR_IRQ_PEND);
        obs_irq();

        if (sbq.size() != 0) begin
            n_tot++;
            $error("FAIL sb_leftover: %0d expectations not observed, required 0", sbq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
